opcode_seq_gen: RTL and testbench

Parametrised opcode stimulus sequencer that drives a programmable sequence of opcodes into the ALU/datapath under test.
- Sequence entries live in an internal table; each entry has a per-entry hold count.
- Supports loop, one-shot and single-step modes, plus pause (en) and abort (stop).
- Replaces the fixed-sequence opcode test generator and loads the same sequence as its reset program.

---
 rtl/opcode_seq_pkg.sv | 34 +++
 rtl/opcode_seq_table.sv | 40 ++++
 rtl/opcode_seq_gen.sv | 164 ++++++++++++++++
 tb/tb_opcode_seq_gen.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_seq_pkg.sv
// rtl/opcode_seq_pkg.sv - shared types and reset program for the opcode sequencer
package opcode_seq_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP    = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_STEP    = 2'd2
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_LEN = 9;

    // Element [0] is the first opcode of the reset program.
    localparam logic [DEFAULT_LEN-1:0][7:0] DEFAULT_PROG = {
        8'h0F, 8'h0E, 8'h0A, 8'h08, 8'h07, 8'h01, 8'h00, 8'h03, 8'h02
    };

    // Reset opcode for any table slot; slots past the program load zero.
    function automatic logic [7:0] default_op(input int idx);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < DEFAULT_LEN; k++) begin
            if (k == idx) begin
                v = DEFAULT_PROG[k];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/opcode_seq_table.sv
// rtl/opcode_seq_table.sv - opcode/hold register file with reset program
module opcode_seq_table #(
    parameter int OP_W   = 4,
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [OP_W-1:0]   i_wr_op,
    input  logic [HOLD_W-1:0] i_wr_hold,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [OP_W-1:0]   o_rd_op,
    output logic [HOLD_W-1:0] o_rd_hold
);
    import opcode_seq_pkg::*;

    logic [OP_W-1:0]   r_op   [DEPTH];
    logic [HOLD_W-1:0] r_hold [DEPTH];

    // Reload the default program on reset, otherwise accept single-entry writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= OP_W'(default_op(i));
                r_hold[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_op[i_wr_addr]   <= i_wr_op;
            r_hold[i_wr_addr] <= i_wr_hold;
        end
    end

    // Reads see the registered contents, so a same-cycle write is not visible yet.
    assign o_rd_op   = r_op[i_rd_addr];
    assign o_rd_hold = r_hold[i_rd_addr];

endmodule

// File: rtl/opcode_seq_gen.sv
// rtl/opcode_seq_gen.sv - programmable opcode stimulus sequencer (top)
module opcode_seq_gen #(
    parameter int  OP_W   = 4,
    parameter int  DEPTH  = 16,
    parameter int  HOLD_W = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_step,
    input  logic [1:0]        i_mode,
    input  logic [AW:0]       i_cfg_len,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [OP_W-1:0]   i_wr_op,
    input  logic [HOLD_W-1:0] i_wr_hold,
    output logic [OP_W-1:0]   o_opcode,
    output logic              o_op_valid,
    output logic [AW-1:0]     o_op_index,
    output logic              o_busy,
    output logic              o_done
);
    import opcode_seq_pkg::*;

    state_e            r_state,    w_state_nx;
    mode_e             r_mode,     w_mode_nx;
    logic [AW:0]       r_len,      w_len_nx;
    logic [AW-1:0]     r_index,    w_index_nx;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nx;
    logic [OP_W-1:0]   r_opcode,   w_opcode_nx;
    logic              r_op_valid, w_valid_nx;
    logic              r_done,     w_done_nx;

    mode_e             w_start_mode;
    logic [AW:0]       w_len_clamped;
    logic [AW-1:0]     w_rd_addr;
    logic [OP_W-1:0]   w_rd_op;
    logic [HOLD_W-1:0] w_rd_hold;
    logic              w_last;
    logic              w_advance;
    logic              w_start_ok;
    logic              w_wr_ok;

    // Reserved mode encoding behaves as one-shot.
    assign w_start_mode  = (i_mode == 2'd0) ? MODE_LOOP :
                           (i_mode == 2'd2) ? MODE_STEP : MODE_ONESHOT;
    assign w_len_clamped = (i_cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_cfg_len;

    assign w_last     = ({1'b0, r_index} == (r_len - (AW+1)'(1)));
    assign w_start_ok = (r_state == ST_IDLE) && i_en && i_start && !i_stop &&
                        (i_cfg_len != '0);
    assign w_wr_ok    = i_wr_en && (r_state == ST_IDLE);

    // One read port serves both the start (entry 0) and every advance (next entry or wrap to 0).
    assign w_rd_addr  = ((r_state == ST_RUN) && !w_last) ? (r_index + AW'(1)) : '0;

    opcode_seq_table #(
        .OP_W   (OP_W),
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W),
        .AW     (AW)
    ) u_table (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (i_wr_addr),
        .i_wr_op   (i_wr_op),
        .i_wr_hold (i_wr_hold),
        .i_rd_addr (w_rd_addr),
        .o_rd_op   (w_rd_op),
        .o_rd_hold (w_rd_hold)
    );

    // Next-state and next-output logic for the IDLE/RUN sequencer.
    always_comb begin
        w_state_nx  = r_state;
        w_mode_nx   = r_mode;
        w_len_nx    = r_len;
        w_index_nx  = r_index;
        w_hold_nx   = r_hold_cnt;
        w_opcode_nx = r_opcode;
        w_valid_nx  = r_op_valid;
        w_done_nx   = 1'b0;
        w_advance   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nx  = ST_RUN;
                    w_mode_nx   = w_start_mode;
                    w_len_nx    = w_len_clamped;
                    w_index_nx  = '0;
                    w_opcode_nx = w_rd_op;
                    w_hold_nx   = w_rd_hold;
                    w_valid_nx  = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    // Abort: opcode keeps its last value, no done pulse.
                    w_state_nx = ST_IDLE;
                    w_valid_nx = 1'b0;
                end else if (i_en) begin
                    if (r_mode == MODE_STEP) begin
                        w_advance = i_step;
                    end else if (r_hold_cnt != '0) begin
                        w_hold_nx = r_hold_cnt - HOLD_W'(1);
                    end else begin
                        w_advance = 1'b1;
                    end

                    if (w_advance) begin
                        if (w_last && (r_mode != MODE_LOOP)) begin
                            w_state_nx = ST_IDLE;
                            w_valid_nx = 1'b0;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_index_nx  = w_rd_addr;
                            w_opcode_nx = w_rd_op;
                            w_hold_nx   = w_rd_hold;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers; done is cleared every cycle so it stays a single pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_LOOP;
            r_len      <= '0;
            r_index    <= '0;
            r_hold_cnt <= '0;
            r_opcode   <= '0;
            r_op_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_mode     <= w_mode_nx;
            r_len      <= w_len_nx;
            r_index    <= w_index_nx;
            r_hold_cnt <= w_hold_nx;
            r_opcode   <= w_opcode_nx;
            r_op_valid <= w_valid_nx;
            r_done     <= w_done_nx;
        end
    end

    assign o_opcode   = r_opcode;
    assign o_op_valid = r_op_valid;
    assign o_op_index = r_index;
    assign o_busy     = (r_state == ST_RUN);
    assign o_done     = r_done;

endmodule

// File: tb/tb_opcode_seq_gen.sv
// tb/tb_opcode_seq_gen.sv - self-checking bench for opcode_seq_gen
module tb_opcode_seq_gen;
    localparam int OP_W   = 4;
    localparam int DEPTH  = 16;
    localparam int HOLD_W = 4;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              start;
    logic              stop;
    logic              step;
    logic [1:0]        mode;
    logic [AW:0]       cfg_len;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [OP_W-1:0]   wr_op;
    logic [HOLD_W-1:0] wr_hold;
    logic [OP_W-1:0]   opcode;
    logic              op_valid;
    logic [AW-1:0]     op_index;
    logic              busy;
    logic              done;

    opcode_seq_gen #(
        .OP_W   (OP_W),
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_start    (start),
        .i_stop     (stop),
        .i_step     (step),
        .i_mode     (mode),
        .i_cfg_len  (cfg_len),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_op    (wr_op),
        .i_wr_hold  (wr_hold),
        .o_opcode   (opcode),
        .o_op_valid (op_valid),
        .o_op_index (op_index),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_op   [DEPTH];
    int m_hold [DEPTH];
    int def_prog [9] = '{2, 3, 0, 1, 7, 8, 10, 14, 15};

    typedef struct {
        logic start;
        int   op;
        int   idx;
        int   valid;
        int   bsy;
        int   dn;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset;
        for (int i = 0; i < DEPTH; i++) begin
            m_op[i]   = 0;
            m_hold[i] = 0;
            if (i < 9) m_op[i] = def_prog[i];
        end
    endtask

    task automatic idle_inputs;
        start = 1'b0; stop = 1'b0; step = 1'b0; wr_en = 1'b0; en = 1'b1;
    endtask

    task automatic write_entry(input int a, input int o, input int h);
        wr_en = 1'b1; wr_addr = AW'(a); wr_op = OP_W'(o); wr_hold = HOLD_W'(h);
        tick;
        wr_en = 1'b0;
        m_op[a] = o; m_hold[a] = h;
    endtask

    task automatic chk_reset_vals;
        chk("rst_opcode", int'(opcode), 0);
        chk("rst_valid", int'(op_valid), 0);
        chk("rst_index", int'(op_index), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
    endtask

    // Expected stream = each active entry repeated hold+1 times; position advances on enabled cycles.
    task automatic run_check(input int md, input int cfg, input int ncyc,
                             input logic [63:0] en_mask, input bit noise, input bit do_stop);
        int eo[$];
        int ei[$];
        int len, sz, p, last_op;
        bit fin;
        len = (cfg > DEPTH) ? DEPTH : cfg;
        for (int i = 0; i < len; i++)
            for (int h = 0; h <= m_hold[i]; h++) begin
                eo.push_back(m_op[i]);
                ei.push_back(i);
            end
        sz = eo.size();
        mode = 2'(md); cfg_len = (AW+1)'(cfg); start = 1'b1; en = 1'b1;
        tick;
        start = 1'b0;
        p = 0; fin = 1'b0; last_op = eo[0];
        for (int k = 1; k <= 300 && !fin; k++) begin
            if (md != 0 && p >= sz) begin
                chk("os_done", int'(done), 1);
                chk("os_end_valid", int'(op_valid), 0);
                chk("os_end_busy", int'(busy), 0);
                chk("os_end_opcode", int'(opcode), eo[sz-1]);
                idle_inputs;
                tick;
                chk("os_done_clear", int'(done), 0);
                chk("os_idle_busy", int'(busy), 0);
                fin = 1'b1;
            end else if (md == 0 && k > ncyc) begin
                last_op = eo[p % sz];
                fin = 1'b1;
            end else begin
                chk("run_opcode", int'(opcode), eo[p % sz]);
                chk("run_index", int'(op_index), ei[p % sz]);
                chk("run_valid", int'(op_valid), 1);
                chk("run_busy", int'(busy), 1);
                chk("run_done", int'(done), 0);
                en = (k - 1 < 64) ? en_mask[k-1] : 1'b1;
                if (noise) begin
                    wr_en = 1'($urandom % 2); wr_addr = AW'($urandom);
                    wr_op = OP_W'($urandom); wr_hold = HOLD_W'($urandom);
                    start = (($urandom % 4) == 0); mode = 2'($urandom);
                    cfg_len = (AW+1)'($urandom); step = 1'($urandom % 2);
                end
                tick;
                if (en) p++;
                wr_en = 1'b0; start = 1'b0; step = 1'b0;
            end
        end
        if (!fin) chk("run_timeout", 0, 1);
        if (do_stop) begin
            stop = 1'b1; start = 1'b1; en = 1'b0;
            tick;
            stop = 1'b0; start = 1'b0; en = 1'b1;
            chk("stop_valid", int'(op_valid), 0);
            chk("stop_busy", int'(busy), 0);
            chk("stop_done", int'(done), 0);
            chk("stop_opcode", int'(opcode), last_op);
            tick;
            chk("stop_stay_idle", int'(busy), 0);
        end
    endtask

    initial begin
        vec_t vt[8];
        logic [63:0] mask;
        int md, nw;

        rst = 1'b1; mode = 2'd0; cfg_len = '0; wr_addr = '0; wr_op = '0; wr_hold = '0;
        idle_inputs;
        model_reset;
        tick;
        chk_reset_vals;
        rst = 1'b0;
        tick;

        // Default program, looping, with wrap from index 8 to 0.
        run_check(0, 9, 20, '1, 1'b0, 1'b1);

        // One-shot with per-entry holds, table-driven.
        write_entry(0, 5, 1);
        write_entry(1, 6, 0);
        write_entry(2, 9, 2);
        vt[0] = '{1'b1, 5, 0, 1, 1, 0};
        vt[1] = '{1'b0, 5, 0, 1, 1, 0};
        vt[2] = '{1'b0, 6, 1, 1, 1, 0};
        vt[3] = '{1'b0, 9, 2, 1, 1, 0};
        vt[4] = '{1'b0, 9, 2, 1, 1, 0};
        vt[5] = '{1'b0, 9, 2, 1, 1, 0};
        vt[6] = '{1'b0, 9, 0, 0, 0, 1};
        vt[7] = '{1'b0, 9, 0, 0, 0, 0};
        mode = 2'd1; cfg_len = 5'd3;
        for (int r = 0; r < 8; r++) begin
            start = vt[r].start; en = 1'b1;
            tick;
            start = 1'b0;
            chk("vec_opcode", int'(opcode), vt[r].op);
            chk("vec_valid", int'(op_valid), vt[r].valid);
            chk("vec_busy", int'(busy), vt[r].bsy);
            chk("vec_done", int'(done), vt[r].dn);
            if (vt[r].valid != 0) chk("vec_index", int'(op_index), vt[r].idx);
        end

        // Step mode: hold ignored, one step every 5 cycles, a step under en=0 is dropped.
        mode = 2'd2; cfg_len = 5'd4; start = 1'b1;
        tick;
        start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 4; w++) begin
                chk("step_opcode", int'(opcode), m_op[s]);
                chk("step_index", int'(op_index), s);
                chk("step_busy", int'(busy), 1);
                en   = !(s == 1 && w == 1);
                step = (s == 1 && w == 1);
                tick;
                step = 1'b0; en = 1'b1;
            end
            step = 1'b1;
            tick;
            step = 1'b0;
        end
        chk("step_done", int'(done), 1);
        chk("step_end_busy", int'(busy), 0);
        chk("step_end_valid", int'(op_valid), 0);
        chk("step_end_opcode", int'(opcode), m_op[3]);
        tick;
        chk("step_done_clear", int'(done), 0);

        // Pause for 3 cycles in the middle of entry 2's hold.
        run_check(0, 3, 15, ~64'h38, 1'b0, 1'b1);

        // Writes, starts and steps while running must all be ignored.
        run_check(0, 3, 20, '1, 1'b1, 1'b1);

        // Write in the same cycle as start: first pass uses old entry 0.
        mode = 2'd0; cfg_len = 5'd1; start = 1'b1;
        wr_en = 1'b1; wr_addr = '0; wr_op = 4'hC; wr_hold = '0;
        tick;
        start = 1'b0; wr_en = 1'b0;
        chk("samecyc_op0", int'(opcode), 5);
        tick;
        chk("samecyc_op1", int'(opcode), 5);
        tick;
        chk("samecyc_op2", int'(opcode), 12);
        tick;
        chk("samecyc_op3", int'(opcode), 12);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("samecyc_stop", int'(busy), 0);
        m_op[0] = 12; m_hold[0] = 0;

        // Zero length start is ignored.
        cfg_len = '0; start = 1'b1;
        tick;
        start = 1'b0;
        chk("len0_busy", int'(busy), 0);
        chk("len0_valid", int'(op_valid), 0);

        // Reset in the middle of a run restores the default program.
        mode = 2'd0; cfg_len = 5'd3; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk_reset_vals;
        rst = 1'b0;
        model_reset;
        run_check(0, 9, 12, '1, 1'b0, 1'b1);

        // Randomized tables, modes, lengths and enable patterns.
        for (int t = 0; t < 10; t++) begin
            idle_inputs;
            nw = $urandom_range(0, 5);
            for (int j = 0; j < nw; j++)
                write_entry($urandom_range(0, DEPTH - 1), $urandom_range(0, 15), $urandom_range(0, 2));
            md = $urandom_range(0, 2);
            if (md == 2) md = 3;
            mask = {$urandom, $urandom} | {$urandom, $urandom};
            run_check(md, $urandom_range(1, 20), 30, mask, 1'b1, md == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
